// File: rtl/wb_rr_arbiter_wdt_if.sv
// Bus bundle for the Wishbone round-robin arbiter: NM master ports on one side,
// a single slave-side port on the other, plus grant/watchdog status.
interface wb_rr_arbiter_wdt_if #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [NM-1:0]        i_m_cyc;
  logic [NM-1:0]        i_m_stb;
  logic [NM-1:0]        i_m_we;
  logic [NM*AW-1:0]     i_m_adr;
  logic [NM*DW-1:0]     i_m_dat;
  logic [NM*DW/8-1:0]   i_m_sel;
  logic [NM-1:0]        o_m_ack;
  logic [NM-1:0]        o_m_err;
  logic [DW-1:0]        o_m_dat;

  logic                 o_s_cyc;
  logic                 o_s_stb;
  logic                 o_s_we;
  logic [AW-1:0]        o_s_adr;
  logic [DW-1:0]        o_s_dat;
  logic [DW/8-1:0]      o_s_sel;
  logic                 i_s_ack;
  logic                 i_s_err;
  logic [DW-1:0]        i_s_dat;

  logic [NM-1:0]        o_grant;
  logic                 o_timeout;

  // Arbiter side
  modport slave (
    input  i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_m_sel,
    output o_m_ack, o_m_err, o_m_dat,
    output o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_dat, o_s_sel,
    input  i_s_ack, i_s_err, i_s_dat,
    output o_grant, o_timeout
  );

  // Environment side: masters and the downstream slave
  modport master (
    output i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_m_sel,
    input  o_m_ack, o_m_err, o_m_dat,
    input  o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_dat, o_s_sel,
    output i_s_ack, i_s_err, i_s_dat,
    input  o_grant, o_timeout
  );
endinterface

// File: rtl/wb_rr_arbiter_wdt.sv
// Wishbone classic round-robin arbiter sharing one slave port among NM masters,
// with a watchdog that terminates stalled strobes with err.
module wb_rr_arbiter_wdt #(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  wb_rr_arbiter_wdt_if.slave   bus
);
  localparam int  SW     = DW / 8;
  localparam int  IW     = (NM > 1) ? $clog2(NM) : 1;
  localparam int  WW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit  WDT_ON = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ABORT = 2'd2} state_t;

  state_t          state, state_n;
  logic [NM-1:0]   grant, grant_n;
  logic [IW-1:0]   last, last_n;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   cand;
  logic            found;
  logic [WW-1:0]   wdt, wdt_n;
  logic            busy, cyc_g, stb_g, stall, fire;

  // Saturating watchdog step: clears whenever the stall condition is absent
  function automatic logic [WW-1:0] wdt_step(input logic [WW-1:0] cur, input logic run);
    if (!run)                 return '0;
    if (cur == WW'(TIMEOUT))  return cur;
    return cur + 1'b1;
  endfunction

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NM; k++)
      if (grant[k]) gidx = IW'(k);
  end

  assign busy  = (state == BUSY);
  assign cyc_g = bus.i_m_cyc[gidx];
  assign stb_g = bus.i_m_stb[gidx];
  assign stall = busy && stb_g && !bus.i_s_ack && !bus.i_s_err;
  // A master dropping cyc is a release, never a timeout
  assign fire  = WDT_ON && busy && cyc_g && (wdt == WW'(TIMEOUT))
                 && !bus.i_s_ack && !bus.i_s_err;

  assign bus.o_s_cyc   = busy && cyc_g;
  assign bus.o_s_stb   = busy && stb_g;
  assign bus.o_s_we    = busy && bus.i_m_we[gidx];
  assign bus.o_s_adr   = busy ? bus.i_m_adr[int'(gidx)*AW +: AW] : '0;
  assign bus.o_s_dat   = busy ? bus.i_m_dat[int'(gidx)*DW +: DW] : '0;
  assign bus.o_s_sel   = busy ? bus.i_m_sel[int'(gidx)*SW +: SW] : '0;
  assign bus.o_m_ack   = {NM{busy && bus.i_s_ack}} & grant;
  assign bus.o_m_err   = {NM{(busy && bus.i_s_err) || fire}} & grant;
  assign bus.o_m_dat   = bus.i_s_dat;
  assign bus.o_grant   = grant;
  assign bus.o_timeout = fire;

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    cand    = '0;
    found   = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.i_m_cyc) begin
          // Search starts just after the last owner so every requester gets a turn
          for (int k = 1; k <= NM; k++) begin
            cand = IW'((int'(last) + k) % NM);
            if (!found && bus.i_m_cyc[cand]) begin
              found   = 1'b1;
              grant_n = '0;
              grant_n[cand] = 1'b1;
            end
          end
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (!cyc_g) begin
          grant_n = '0;
          last_n  = gidx;
          state_n = IDLE;
        end else if (fire) begin
          state_n = ABORT;
        end
      end
      ABORT: begin
        if (!cyc_g) begin
          grant_n = '0;
          last_n  = gidx;
          state_n = IDLE;
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
    wdt_n = wdt_step(wdt, WDT_ON && stall);
    if (state_n != BUSY) wdt_n = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= IW'(NM - 1);
      wdt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last  <= last_n;
      wdt   <= wdt_n;
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter_wdt.sv
// Directed bench for wb_rr_arbiter_wdt: per-cycle vector table plus hand-written
// block, wait-state, timeout, ack-at-timeout and mid-transfer reset sequences.
module tb_wb_rr_arbiter_wdt;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  wb_rr_arbiter_wdt_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

  wb_rr_arbiter_wdt #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_time_limit act=running req=finished");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic        ack;
    logic        err;
    logic [1:0]  g;
    logic        scyc;
    logic        sstb;
    logic [1:0]  mack;
    logic [1:0]  merr;
    logic        to;
    logic [31:0] adr;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic [1:0] cyc, logic [1:0] stb, logic ack, logic err,
                              logic [1:0] g, logic scyc, logic sstb, logic [1:0] mack,
                              logic [1:0] merr, logic to, logic [31:0] adr);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.g = g; v.scyc = scyc;
    v.sstb = sstb; v.mack = mack; v.merr = merr; v.to = to; v.adr = adr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] cyc, input logic [1:0] stb, input logic ack, input logic err);
    bus.i_m_cyc = cyc;
    bus.i_m_stb = stb;
    bus.i_s_ack = ack;
    bus.i_s_err = err;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Master 0: write to 0x10; master 1: read from 0x100
    bus.i_m_we  = 2'b01;
    bus.i_m_adr = {32'h0000_0100, 32'h0000_0010};
    bus.i_m_dat = {32'h0000_B1B1, 32'h0000_A0A0};
    bus.i_m_sel = {4'h3, 4'hF};
    bus.i_s_dat = 32'hDEAD_BEEF;
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    rst = 1'b1;

    //             cyc    stb    ack err g      scyc sstb mack   merr   to  adr
    tbl[0]  = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0);
    tbl[1]  = mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0);
    tbl[2]  = mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 0, 32'h10);
    tbl[3]  = mk(2'b10, 2'b10, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 32'h10);
    tbl[4]  = mk(2'b10, 2'b10, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0);
    tbl[5]  = mk(2'b10, 2'b10, 0, 0, 2'b10, 1, 1, 2'b00, 2'b00, 0, 32'h100);
    tbl[6]  = mk(2'b10, 2'b10, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 0, 32'h100);
    tbl[7]  = mk(2'b00, 2'b00, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 0, 32'h100);
    tbl[8]  = mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0);
    tbl[9]  = mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 0, 32'h10);
    tbl[10] = mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 0, 32'h10);
    tbl[11] = mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 0, 32'h10);
    tbl[12] = mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 0, 32'h10);
    tbl[13] = mk(2'b10, 2'b10, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 32'h10);
    tbl[14] = mk(2'b10, 2'b10, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0);
    tbl[15] = mk(2'b10, 2'b10, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 0, 32'h100);
    tbl[16] = mk(2'b00, 2'b00, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 0, 32'h100);
    tbl[17] = mk(2'b01, 2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0);
    tbl[18] = mk(2'b01, 2'b01, 1, 1, 2'b01, 1, 1, 2'b01, 2'b01, 0, 32'h10);
    tbl[19] = mk(2'b01, 2'b01, 0, 1, 2'b01, 1, 1, 2'b00, 2'b01, 0, 32'h10);
    tbl[20] = mk(2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 32'h10);
    tbl[21] = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0);

    tick();
    tick();
    @(negedge clk);
    chk("rst_grant", 32'(bus.o_grant), 32'h0);
    chk("rst_s_cyc", 32'(bus.o_s_cyc), 32'h0);
    chk("rst_timeout", 32'(bus.o_timeout), 32'h0);
    tick();
    rst = 1'b0;

    // Per-cycle vectors: round-robin handover, block cycle, ack+err
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].cyc, tbl[i].stb, tbl[i].ack, tbl[i].err);
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), 32'(bus.o_grant), 32'(tbl[i].g));
      chk($sformatf("v%0d_s_cyc", i), 32'(bus.o_s_cyc), 32'(tbl[i].scyc));
      chk($sformatf("v%0d_s_stb", i), 32'(bus.o_s_stb), 32'(tbl[i].sstb));
      chk($sformatf("v%0d_m_ack", i), 32'(bus.o_m_ack), 32'(tbl[i].mack));
      chk($sformatf("v%0d_m_err", i), 32'(bus.o_m_err), 32'(tbl[i].merr));
      chk($sformatf("v%0d_timeout", i), 32'(bus.o_timeout), 32'(tbl[i].to));
      chk($sformatf("v%0d_s_adr", i), bus.o_s_adr, tbl[i].adr);
      tick();
    end

    // m1 read with 3 wait states
    drive(2'b10, 2'b10, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ws%0d_m_ack", k), 32'(bus.o_m_ack), 32'h0);
      tick();
    end
    bus.i_s_ack = 1'b1;
    @(negedge clk);
    chk("rd_m_ack", 32'(bus.o_m_ack), 32'h2);
    chk("rd_m_dat", bus.o_m_dat, 32'hDEAD_BEEF);
    chk("rd_s_adr", bus.o_s_adr, 32'h100);
    chk("rd_s_we", 32'(bus.o_s_we), 32'h0);
    chk("rd_s_sel", 32'(bus.o_s_sel), 32'h3);
    chk("rd_s_dat", bus.o_s_dat, 32'h0000_B1B1);
    tick();
    drive(2'b10, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("rd_after_m_ack", 32'(bus.o_m_ack), 32'h0);
    tick();
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    tick();

    // Watchdog fires on the 9th stalled strobe cycle
    drive(2'b01, 2'b01, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("wdt%0d_timeout", k), 32'(bus.o_timeout), (k == 9) ? 32'h1 : 32'h0);
      chk($sformatf("wdt%0d_m_err", k), 32'(bus.o_m_err), (k == 9) ? 32'h1 : 32'h0);
      tick();
    end
    bus.i_s_ack = 1'b1;
    @(negedge clk);
    chk("abort_s_cyc", 32'(bus.o_s_cyc), 32'h0);
    chk("abort_s_stb", 32'(bus.o_s_stb), 32'h0);
    chk("abort_grant", 32'(bus.o_grant), 32'h1);
    chk("abort_m_ack", 32'(bus.o_m_ack), 32'h0);
    chk("abort_timeout", 32'(bus.o_timeout), 32'h0);
    tick();
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("abort_rel_grant", 32'(bus.o_grant), 32'h1);
    tick();
    @(negedge clk);
    chk("abort_idle_grant", 32'(bus.o_grant), 32'h0);
    tick();

    // Ack lands exactly when the watchdog would fire
    drive(2'b01, 2'b01, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 8; k++) tick();
    bus.i_s_ack = 1'b1;
    @(negedge clk);
    chk("race_m_ack", 32'(bus.o_m_ack), 32'h1);
    chk("race_m_err", 32'(bus.o_m_err), 32'h0);
    chk("race_timeout", 32'(bus.o_timeout), 32'h0);
    tick();
    bus.i_s_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("race_after%0d_timeout", k), 32'(bus.o_timeout), 32'h0);
      chk($sformatf("race_after%0d_s_cyc", k), 32'(bus.o_s_cyc), 32'h1);
      tick();
    end
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    tick();

    // Async reset in the middle of a strobed transfer
    drive(2'b11, 2'b11, 1'b0, 1'b0);
    tick();
    bus.i_s_ack = 1'b1;
    @(negedge clk);
    chk("pre_rst_grant", 32'(bus.o_grant), 32'h2);
    chk("pre_rst_m_ack", 32'(bus.o_m_ack), 32'h2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(bus.o_grant), 32'h0);
    chk("mid_rst_s_cyc", 32'(bus.o_s_cyc), 32'h0);
    chk("mid_rst_s_stb", 32'(bus.o_s_stb), 32'h0);
    chk("mid_rst_s_adr", bus.o_s_adr, 32'h0);
    chk("mid_rst_m_ack", 32'(bus.o_m_ack), 32'h0);
    tick();
    rst = 1'b0;
    bus.i_s_ack = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_grant", 32'(bus.o_grant), 32'h0);
    tick();
    @(negedge clk);
    chk("post_rst_grant", 32'(bus.o_grant), 32'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
